led_7seg_controller: RTL and testbench
======================================

# led_7seg_controller

Multiplexed driver for a 4-digit, common-anode 7-segment display with decimal points. Holds one 8-bit pattern per digit in a small register file written through a simple write port. It scans the digits round-robin at a parameterised rate and drives the shared active-low segment and dot lines plus the active-low digit enables. It sits between a bus or user-logic writer and the board's display pins.

## Interface
- `FPGA_FREQ`, default 100_000_000: input clock frequency in Hz.
- `REFRESH_FREQ`, default 1000: per-digit switch rate in Hz.
  - Dwell per digit is `DIV = max(1, FPGA_FREQ/REFRESH_FREQ)` cycles, using integer division.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset (low = reset).
- `en_w`, input, 1: write enable.
- `waddr`, input, 2: digit register to write (0..3).
- `data`, input, 8: `data[7]` is the dot (1 = lit); `data[6:0]` is the segment pattern, gfedcba order, active-low (0 = segment lit).
- `LED_enables`, output, 4: digit anodes, active-low, one-hot-low while scanning.
- `LED_7SEG`, output, 7: segment cathodes, active-low.
- `LED_dot`, output, 1: decimal-point cathode, active-low.

## Operation
- Register file: 4 × 8 bits, `digit_reg[0..3]`.
  - On reset, each entry becomes 8'h7F (segments blank, dot off).
- Write: at a clock edge with `rst` high and `en_w` = 1, `digit_reg[waddr]` is loaded with `data`.
  - A new write may be issued every cycle; the last value written wins.
  - While `rst` is low, writes are ignored.
- Scan: a tick counter runs 0..DIV-1 and wraps to 0. At the wrap the digit index advances 0→1→2→3→0.
  - The counter is free-running; `en_w` does not affect it.
- Outputs are registered. At each edge:
  - `LED_enables` = ~(4'b0001 << idx)
  - `LED_7SEG` = `digit_reg[idx][6:0]`
  - `LED_dot` = ~`digit_reg[idx][7]`
- No content decoding: callers supply raw segment patterns.
- Reset values: `LED_enables` = 4'b1111, `LED_7SEG` = 7'b1111111, `LED_dot` = 1, tick counter = 0, idx = 0.
- Reset mid-scan: outputs blank immediately (asynchronous reset), and the register contents are cleared.

## Timing
- Write latency: data written at edge N is visible on the pins at edge N+1 if `idx` selects that digit at N+1. Otherwise it appears when the scan next reaches that digit.
- After reset release, the first edge drives digit 0 (`LED_enables` = 4'b1110).
- Each digit is driven for exactly DIV cycles. A full scan takes 4·DIV cycles.
- Digit switch: enables and segments change on the same edge. There is no blanking interval.
- A write and a scan advance at the same edge are independent: the write lands, and the scan moves on.
- DIV = 1: the digit advances every cycle.

## Structure
- Shared package `led7seg_pkg` contains:
  - enum `led_7seg_values_t` holding the active-low patterns 0–9, A–F (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110, etc.);
  - localparam `NUM_DIGITS` = 4;
  - localparam `BLANK` = 7'b1111111.
- One sub-module, `clk_divider`, takes the `DIV` parameter and produces a one-cycle `tick` enable, not a derived clock. All other logic stays in the top module.

## Test plan
Use FPGA_FREQ = 5 and REFRESH_FREQ = 1 (DIV = 5) for all scenarios.
- Reset: hold `rst` = 0 with `en_w` = 1. Required: outputs stay 4'b1111 / 7'b1111111 / 1, and no register is written.
- Release and scan: after reset release with no writes, `LED_enables` cycles 1110→1101→1011→0111→1110, each for 5 cycles. Segments stay 7'b1111111 and `LED_dot` stays 1.
- Write digit 0 with `data` = {1, ONE} = 8'hF9. Required: while digit 0 is active, `LED_7SEG` = 7'b1111001 and `LED_dot` = 0; the other digits remain blank.
- Write all digits:
  - addr 1 ← THREE, dot 0
  - addr 2 ← A, dot 0
  - addr 3 ← F, dot 1
  
  Required: the scan shows 1111001/0, 0110000/1, 0001000/1, 0001110/0 on digits 0..3 respectively.
- Hold: set `en_w` = 0 while `data` keeps changing. Required: the displayed patterns remain unchanged for 140+ cycles.
- Mid-scan reset: assert `rst` low in the middle of a digit's dwell. Required: outputs blank immediately. After release, the scan restarts at digit 0 and all digits are blank.

Source files
------------

// File: rtl/led7seg_pkg.sv
// Shared constants and segment encodings for the 7-segment display controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package led7seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    // Active-low gfedcba patterns for hex glyphs (0 = segment lit)
    typedef enum logic [6:0] {
        SEG_0 = 7'b1000000,
        SEG_1 = 7'b1111001,
        SEG_2 = 7'b0100100,
        SEG_3 = 7'b0110000,
        SEG_4 = 7'b0011001,
        SEG_5 = 7'b0010010,
        SEG_6 = 7'b0000010,
        SEG_7 = 7'b1111000,
        SEG_8 = 7'b0000000,
        SEG_9 = 7'b0010000,
        SEG_A = 7'b0001000,
        SEG_B = 7'b0000011,
        SEG_C = 7'b1000110,
        SEG_D = 7'b0100001,
        SEG_E = 7'b0000110,
        SEG_F = 7'b0001110
    } led_7seg_values_t;

endpackage

// File: rtl/led_7seg_controller_clk_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick enable on its last count.
// Latency: tick is combinational from the counter state, high every DIV-th cycle.
// Backpressure: none; runs continuously.
module clk_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the final count, wrap to zero on the same cycle
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_7seg_controller.sv
// Multiplexed 4-digit common-anode 7-segment driver with per-digit pattern registers.
// Latency: pins registered; a write shows one edge later if its digit is being scanned.
// Backpressure: none; writes accepted every cycle, scan is free-running.
module led_7seg_controller
    import led7seg_pkg::*;
#(
    parameter int FPGA_FREQ    = 100_000_000,
    parameter int REFRESH_FREQ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_w,
    input  logic [1:0] waddr,
    input  logic [7:0] data,
    output logic [3:0] LED_enables,
    output logic [6:0] LED_7SEG,
    output logic       LED_dot
);

    // Dwell per digit in cycles, never below one
    localparam int RATIO = FPGA_FREQ / REFRESH_FREQ;
    localparam int DIV   = (RATIO < 1) ? 1 : RATIO;

    logic       tick;
    logic [7:0] digit_reg_q [NUM_DIGITS];
    logic [7:0] digit_reg_d [NUM_DIGITS];
    logic [1:0] idx_q, idx_d;
    logic [3:0] led_enables_q, led_enables_d;
    logic [6:0] led_7seg_q, led_7seg_d;
    logic       led_dot_q, led_dot_d;

    clk_divider #(
        .DIV (DIV)
    ) u_clk_divider (
        .clk   (clk),
        .rst_n (rst),
        .tick  (tick)
    );

    // Register file update: last write to an address wins
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_reg_d[i] = digit_reg_q[i];
        end
        if (en_w) begin
            digit_reg_d[waddr] = data;
        end
    end

    // Scan index advances at each divider wrap, independent of writes
    always_comb begin
        idx_d = tick ? idx_q + 2'd1 : idx_q;
    end

    // Pin values for the digit currently selected by the scan
    always_comb begin
        led_enables_d = ~(4'b0001 << idx_q);
        led_7seg_d    = digit_reg_q[idx_q][6:0];
        led_dot_d     = ~digit_reg_q[idx_q][7];
    end

    // State and output registers; reset blanks the display and clears patterns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg_q[i] <= 8'h7F;
            end
            idx_q         <= 2'd0;
            led_enables_q <= 4'b1111;
            led_7seg_q    <= BLANK;
            led_dot_q     <= 1'b1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg_q[i] <= digit_reg_d[i];
            end
            idx_q         <= idx_d;
            led_enables_q <= led_enables_d;
            led_7seg_q    <= led_7seg_d;
            led_dot_q     <= led_dot_d;
        end
    end

    assign LED_enables = led_enables_q;
    assign LED_7SEG    = led_7seg_q;
    assign LED_dot     = led_dot_q;

endmodule

// File: tb/tb_led_7seg_controller.sv
// Self-checking bench: behavioural scan model plus literal pins for key scenarios.
module tb_led_7seg_controller;
    import led7seg_pkg::*;

    localparam int FF  = 5;
    localparam int RF  = 1;
    localparam int DIV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_w = 1'b0;
    logic [1:0] waddr = 2'd0;
    logic [7:0] data = 8'h00;
    logic [3:0] LED_enables;
    logic [6:0] LED_7SEG;
    logic       LED_dot;

    int checks = 0;
    int failures = 0;

    led_7seg_controller #(
        .FPGA_FREQ    (FF),
        .REFRESH_FREQ (RF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_w        (en_w),
        .waddr       (waddr),
        .data        (data),
        .LED_enables (LED_enables),
        .LED_7SEG    (LED_7SEG),
        .LED_dot     (LED_dot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: digit shown at the k-th edge after release is ((k-1)/DIV)%4,
    // pattern is the register content as written before that edge.
    logic [7:0] m_regs [4];
    int         since;
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_dot;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h7F;
            since   = 0;
            exp_en  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dot = 1'b1;
        end else begin
            int d;
            d       = (since / DIV) % 4;
            exp_en  = 4'b1111;
            exp_en[d] = 1'b0;
            exp_seg = m_regs[d][6:0];
            exp_dot = ~m_regs[d][7];
            since++;
            if (en_w) m_regs[waddr] = data;
        end
    end

    // Every-cycle comparison of the pins against the model
    always @(negedge clk) begin
        chk("model_en",  {28'd0, LED_enables}, {28'd0, exp_en});
        chk("model_seg", {25'd0, LED_7SEG},    {25'd0, exp_seg});
        chk("model_dot", {31'd0, LED_dot},     {31'd0, exp_dot});
    end

    function automatic int digit_of(input logic [3:0] en);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (en == ~(4'b0001 << i)) r = i;
        return r;
    endfunction

    // Literal expectations for the fully written display
    logic [6:0] lit_seg [4];
    logic       lit_dot [4];

    initial begin
        lit_seg[0] = 7'b1111001; lit_dot[0] = 1'b0;
        lit_seg[1] = 7'b0110000; lit_dot[1] = 1'b1;
        lit_seg[2] = 7'b0001000; lit_dot[2] = 1'b1;
        lit_seg[3] = 7'b0001110; lit_dot[3] = 1'b0;

        // Reset held with write enable active
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            en_w = 1'b1; waddr = 2'($urandom_range(0, 3)); data = 8'($urandom);
            chk("rst_en",  {28'd0, LED_enables}, 32'hF);
            chk("rst_seg", {25'd0, LED_7SEG},    32'h7F);
            chk("rst_dot", {31'd0, LED_dot},     32'h1);
        end

        // Release and scan with no writes
        @(negedge clk);
        en_w = 1'b0; rst = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk("scan_blank_seg", {25'd0, LED_7SEG}, 32'h7F);
            chk("scan_blank_dot", {31'd0, LED_dot},  32'h1);
            if (k == 1)  chk("scan_d0", {28'd0, LED_enables}, 32'hE);
            if (k == 5)  chk("scan_d0_end", {28'd0, LED_enables}, 32'hE);
            if (k == 6)  chk("scan_d1", {28'd0, LED_enables}, 32'hD);
            if (k == 11) chk("scan_d2", {28'd0, LED_enables}, 32'hB);
            if (k == 16) chk("scan_d3", {28'd0, LED_enables}, 32'h7);
            if (k == 21) chk("scan_wrap", {28'd0, LED_enables}, 32'hE);
        end

        // Write digit 0 with a lit dot and glyph 1
        en_w = 1'b1; waddr = 2'd0; data = {1'b1, SEG_1};
        @(negedge clk);
        en_w = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (digit_of(LED_enables) == 0) begin
                chk("d0_seg", {25'd0, LED_7SEG}, 32'h79);
                chk("d0_dot", {31'd0, LED_dot},  32'h0);
            end else begin
                chk("other_blank", {25'd0, LED_7SEG}, 32'h7F);
            end
        end

        // Write the remaining digits
        en_w = 1'b1; waddr = 2'd1; data = {1'b0, SEG_3};
        @(negedge clk);
        waddr = 2'd2; data = {1'b0, SEG_A};
        @(negedge clk);
        waddr = 2'd3; data = {1'b1, SEG_F};
        @(negedge clk);
        en_w = 1'b0;
        @(negedge clk);

        // Hold: data wiggles with writes disabled
        for (int k = 0; k < 150; k++) begin
            data = 8'($urandom); waddr = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (digit_of(LED_enables) < 0) begin
                chk("onehot", {28'd0, LED_enables}, 32'hE);
            end else begin
                chk("all_seg", {25'd0, LED_7SEG}, {25'd0, lit_seg[digit_of(LED_enables)]});
                chk("all_dot", {31'd0, LED_dot},  {31'd0, lit_dot[digit_of(LED_enables)]});
            end
        end

        // Random writes checked by the model
        for (int k = 0; k < 400; k++) begin
            en_w  = ($urandom_range(0, 3) == 0);
            waddr = 2'($urandom_range(0, 3));
            data  = 8'($urandom);
            @(negedge clk);
        end
        en_w = 1'b0;

        // Mid-dwell reset: wait for the third cycle of a digit
        while (((since - 1) % DIV) != 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_en",  {28'd0, LED_enables}, 32'hF);
        chk("midrst_seg", {25'd0, LED_7SEG},    32'h7F);
        chk("midrst_dot", {31'd0, LED_dot},     32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("post_rst_d0", {28'd0, LED_enables}, 32'hE);
            chk("post_rst_seg", {25'd0, LED_7SEG}, 32'h7F);
            chk("post_rst_dot", {31'd0, LED_dot},  32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
